// File: rtl/adc_spi_responder_pkg.sv
// Shared types and constants for the MCP3002-style SPI responder.
package adc_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_CMD        = 3'd2,
        ST_NULLB      = 3'd3,
        ST_DATA       = 3'd4,
        ST_TAIL       = 3'd5,
        ST_DONE       = 3'd6
    } adc_resp_state_e;

    localparam int DATA_W_DEF = 10;
    localparam int CMD_BITS   = 3;

    // Position of each command field in the post-start-bit sequence.
    localparam int CMD_SGL  = 0;
    localparam int CMD_ODD  = 1;
    localparam int CMD_MSBF = 2;

endpackage

// File: rtl/adc_spi_responder_pin_sync.sv
// Synchronisers and edge detectors for the SPI pins (cs, sck, sdi).
// Edges are held off after reset until the chains hold real pin samples.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    input  logic sck,
    input  logic sdi,
    output logic cs_s,
    output logic cs_rise,
    output logic cs_fall,
    output logic sck_rise,
    output logic sck_fall,
    output logic sdi_s
);

    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] sdi_sr;
    logic                   cs_p;
    logic                   sck_p;
    logic [SYNC_STAGES:0]   prime;
    logic                   armed;
    logic                   sck_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sr  <= '1;
            sck_sr <= '0;
            sdi_sr <= '0;
            cs_p   <= 1'b1;
            sck_p  <= 1'b0;
            prime  <= '0;
        end else begin
            cs_sr  <= {cs_sr[SYNC_STAGES-2:0], cs};
            sck_sr <= {sck_sr[SYNC_STAGES-2:0], sck};
            sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], sdi};
            cs_p   <= cs_s;
            sck_p  <= sck_s;
            prime  <= {prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s  = cs_sr[SYNC_STAGES-1];
    assign sck_s = sck_sr[SYNC_STAGES-1];
    assign sdi_s = sdi_sr[SYNC_STAGES-1];

    // A cs already low when reset ends must not look like a frame start.
    assign armed    = prime[SYNC_STAGES];
    assign cs_rise  = armed &  cs_s & ~cs_p;
    assign cs_fall  = armed & ~cs_s &  cs_p;
    assign sck_rise = armed & ~cs_s &  sck_s & ~sck_p;
    assign sck_fall = armed & ~cs_s & ~sck_s &  sck_p;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 2-channel MCP3002 ADC, oversampled in sysclk.
// Define ADC_RESP_LSB_TAIL_EN to enable the LSB-first tail when MSBF=0.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              adc_cs,
    input  logic              adc_sck,
    input  logic              sdata_to_adc,
    output logic              sdata_from_adc,
    output logic              sdo_oe,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic [DATA_W-1:0] ch1_data,
    output logic [1:0]        chan_sel,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] IDLE       = ST_IDLE;
    localparam logic [2:0] WAIT_START = ST_WAIT_START;
    localparam logic [2:0] CMD        = ST_CMD;
    localparam logic [2:0] NULLB      = ST_NULLB;
    localparam logic [2:0] DATA       = ST_DATA;
    localparam logic [2:0] TAIL       = ST_TAIL;
    localparam logic [2:0] DONE       = ST_DONE;

    localparam int IDX_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2(CMD_BITS);

`ifdef ADC_RESP_LSB_TAIL_EN
    localparam logic TAIL_EN = 1'b1;
`else
    localparam logic TAIL_EN = 1'b0;
`endif

    logic              cs_s, cs_rise, cs_fall, sck_rise, sck_fall, sdi_s;
    logic [2:0]        state;
    logic [CNT_W-1:0]  cmd_cnt;
    logic              sgl_r;
    logic              msbf_r;
    logic [DATA_W-1:0] sr;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_inc;
    logic              data_last;
    logic              oe_q;
    logic [DATA_W:0]   diff_01;
    logic [DATA_W:0]   diff_10;
    logic [DATA_W-1:0] sample;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (sysclk),
        .reset    (reset),
        .cs       (adc_cs),
        .sck      (adc_sck),
        .sdi      (sdata_to_adc),
        .cs_s     (cs_s),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .sdi_s    (sdi_s)
    );

    // Sample selection evaluated at the ODD/SIGN rise, sdi_s carrying ODD.
    assign diff_01 = {1'b0, ch0_data} - {1'b0, ch1_data};
    assign diff_10 = {1'b0, ch1_data} - {1'b0, ch0_data};

    always_comb begin
        sample = '0;
        if (sgl_r) begin
            sample = sdi_s ? ch1_data : ch0_data;
        end else if (!sdi_s) begin
            sample = diff_01[DATA_W] ? '0 : diff_01[DATA_W-1:0];
        end else begin
            sample = diff_10[DATA_W] ? '0 : diff_10[DATA_W-1:0];
        end
    end

    assign idx_inc = idx + IDX_W'(1);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state          <= IDLE;
            cmd_cnt        <= '0;
            sgl_r          <= 1'b0;
            msbf_r         <= 1'b0;
            sr             <= '0;
            idx            <= '0;
            data_last      <= 1'b0;
            oe_q           <= 1'b0;
            sdata_from_adc <= 1'b0;
            chan_sel       <= 2'b00;
            frame_done     <= 1'b0;
            frame_abort    <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            // cs rising wins over any sck edge seen in the same cycle.
            if (cs_rise) begin
                state          <= IDLE;
                oe_q           <= 1'b0;
                sdata_from_adc <= 1'b0;
                if (state == DONE || (state == DATA && data_last)) begin
                    frame_done <= 1'b1;
                end else if (state != IDLE && state != WAIT_START) begin
                    frame_abort <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        oe_q <= 1'b0;
                        if (cs_fall) begin
                            state <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (sck_rise && sdi_s) begin
                            state   <= CMD;
                            cmd_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            cmd_cnt <= cmd_cnt + CNT_W'(1);
                            if (cmd_cnt == CNT_W'(CMD_SGL)) begin
                                sgl_r <= sdi_s;
                            end else if (cmd_cnt == CNT_W'(CMD_ODD)) begin
                                sr       <= sample;
                                chan_sel <= {sgl_r, sdi_s};
                            end else begin
                                msbf_r <= sdi_s;
                                state  <= NULLB;
                            end
                        end
                    end
                    NULLB: begin
                        if (sck_fall) begin
                            oe_q           <= 1'b1;
                            sdata_from_adc <= 1'b0;
                            idx            <= IDX_W'(DATA_W - 1);
                            data_last      <= 1'b0;
                            state          <= DATA;
                        end
                    end
                    DATA: begin
                        if (sck_fall) begin
                            if (!data_last) begin
                                sdata_from_adc <= sr[idx];
                                if (idx == '0) begin
                                    data_last <= 1'b1;
                                end else begin
                                    idx <= idx - IDX_W'(1);
                                end
                            end else if (TAIL_EN && !msbf_r) begin
                                sdata_from_adc <= sr[1];
                                idx            <= IDX_W'(1);
                                state          <= TAIL;
                            end else begin
                                sdata_from_adc <= 1'b0;
                                state          <= DONE;
                            end
                        end
                    end
                    TAIL: begin
                        if (sck_fall) begin
                            sdata_from_adc <= sr[idx_inc];
                            idx            <= idx_inc;
                            if (idx_inc == IDX_W'(DATA_W - 1)) begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (sck_fall) begin
                            sdata_from_adc <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // sdata_from_adc is meaningful only while sdo_oe is high.
    assign sdo_oe    = oe_q & ~cs_s;
    assign state_dbg = state;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed scoreboard bench for adc_spi_responder: bits and frame pulses are
// queued by the stimulus thread and checked by independent monitors.
module tb_adc_spi_responder;

    localparam int HALF = 25;
    localparam int SYNC = 2;

    logic       sysclk;
    logic       reset;
    logic       adc_cs;
    logic       adc_sck;
    logic       sdata_to_adc;
    logic       sdata_from_adc;
    logic       sdo_oe;
    logic [9:0] ch0_data;
    logic [9:0] ch1_data;
    logic [1:0] chan_sel;
    logic       frame_done;
    logic       frame_abort;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:0] exp_q[$];
    logic [1:0] ev_q[$];

    adc_spi_responder #(.SYNC_STAGES(SYNC), .DATA_W(10)) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .adc_cs         (adc_cs),
        .adc_sck        (adc_sck),
        .sdata_to_adc   (sdata_to_adc),
        .sdata_from_adc (sdata_from_adc),
        .sdo_oe         (sdo_oe),
        .ch0_data       (ch0_data),
        .ch1_data       (ch1_data),
        .chan_sel       (chan_sel),
        .frame_done     (frame_done),
        .frame_abort    (frame_abort),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial sysclk = 1'b0;
    always #10 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic sck_cycle(input logic b);
        sdata_to_adc = b;
        wait_cyc(HALF);
        adc_sck = 1'b1;
        wait_cyc(HALF);
        adc_sck = 1'b0;
    endtask

    task automatic send_cmd(input int lead, input logic sgl, input logic odd, input logic msbf);
        adc_cs = 1'b0;
        wait_cyc(8);
        repeat (lead) sck_cycle(1'b0);
        sck_cycle(1'b1);
        sck_cycle(sgl);
        sck_cycle(odd);
        sck_cycle(msbf);
    endtask

    task automatic end_frame(input string name);
        wait_cyc(8);
        adc_cs = 1'b1;
        wait_cyc(12);
        check({name, "_bits_left"}, exp_q.size(), 0);
        check({name, "_pulses_left"}, ev_q.size(), 0);
    endtask

    task automatic push_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    // scoreboard monitors: bits at the initiator's sampling edge, pulses per cycle
    always @(posedge adc_sck) begin
        if (!adc_cs && sdo_oe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sdo_unexpected: got %0b expected no driven bit at %0t", sdata_from_adc, $time);
            end else begin
                check("sdo_bit", {31'b0, sdata_from_adc}, {31'b0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge sysclk) begin
        if (frame_done || frame_abort) begin
            if (ev_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pulse_unexpected: got {abort,done}=%b expected none at %0t",
                         {frame_abort, frame_done}, $time);
            end else begin
                check("frame_pulse", {30'b0, frame_abort, frame_done}, {30'b0, ev_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1; adc_cs = 1'b1; adc_sck = 1'b0; sdata_to_adc = 1'b0;
        ch0_data = '0; ch1_data = '0;
        wait_cyc(4);
        check("rst_sdo", {31'b0, sdata_from_adc}, 0);
        check("rst_oe", {31'b0, sdo_oe}, 0);
        check("rst_chan_sel", {30'b0, chan_sel}, 0);
        check("rst_pulses", {30'b0, frame_abort, frame_done}, 0);
        check("rst_state", {29'b0, state_dbg}, 0);
        reset = 1'b0;
        wait_cyc(6);

        // single-ended ch0, MSBF=1
        ch0_data = 10'h2A5; ch1_data = 10'h0F0;
        exp_q.push_back(1'b0); push_word(10'b1010100101); exp_q.push_back(1'b0);
        ev_q.push_back(2'b01);
        send_cmd(0, 1'b1, 1'b0, 1'b1);
        repeat (12) sck_cycle(1'b0);
        end_frame("t1");
        check("t1_chan_sel", {30'b0, chan_sel}, 32'h2);

        // single-ended ch1; inputs change after the latch point
        ch0_data = 10'h0AA; ch1_data = 10'h3FF;
        exp_q.push_back(1'b0); push_word(10'b1111111111); exp_q.push_back(1'b0);
        ev_q.push_back(2'b01);
        send_cmd(0, 1'b1, 1'b1, 1'b1);
        repeat (3) sck_cycle(1'b0);
        ch0_data = 10'h3FF; ch1_data = 10'h000;
        repeat (9) sck_cycle(1'b0);
        end_frame("t2");
        check("t2_chan_sel", {30'b0, chan_sel}, 32'h3);

        // differential ch0-ch1 saturates to zero
        ch0_data = 10'd100; ch1_data = 10'd300;
        exp_q.push_back(1'b0); push_word(10'b0000000000); exp_q.push_back(1'b0);
        ev_q.push_back(2'b01);
        send_cmd(0, 1'b0, 1'b0, 1'b1);
        repeat (12) sck_cycle(1'b0);
        end_frame("t3");
        check("t3_chan_sel", {30'b0, chan_sel}, 32'h0);

        // differential ch1-ch0 = 200
        exp_q.push_back(1'b0); push_word(10'b0011001000); exp_q.push_back(1'b0);
        ev_q.push_back(2'b01);
        send_cmd(0, 1'b0, 1'b1, 1'b1);
        repeat (12) sck_cycle(1'b0);
        end_frame("t4");
        check("t4_chan_sel", {30'b0, chan_sel}, 32'h1);

        // leading zeros before the start bit
        ch0_data = 10'h155;
        exp_q.push_back(1'b0); push_word(10'b0101010101); exp_q.push_back(1'b0);
        ev_q.push_back(2'b01);
        send_cmd(3, 1'b1, 1'b0, 1'b1);
        repeat (12) sck_cycle(1'b0);
        end_frame("t5");
        check("t5_chan_sel", {30'b0, chan_sel}, 32'h2);

        // abort after four data bits driven (null,B9,B8,B7 sampled)
        ch0_data = 10'h2A5;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        ev_q.push_back(2'b10);
        send_cmd(0, 1'b1, 1'b0, 1'b1);
        repeat (4) sck_cycle(1'b0);
        wait_cyc(6);
        adc_cs = 1'b1;
        wait_cyc(SYNC + 1);
        check("t6_oe_off", {31'b0, sdo_oe}, 0);
        check("t6_sdo_low", {31'b0, sdata_from_adc}, 0);
        wait_cyc(10);
        check("t6_bits_left", exp_q.size(), 0);
        check("t6_pulses_left", ev_q.size(), 0);

        // MSBF=0: LSB-first tail when enabled, zeros otherwise
        ch0_data = 10'h201;
        exp_q.push_back(1'b0); push_word(10'b1000000001);
`ifdef ADC_RESP_LSB_TAIL_EN
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
`else
        for (int i = 0; i < 9; i++) exp_q.push_back(1'b0);
`endif
        ev_q.push_back(2'b01);
        send_cmd(0, 1'b1, 1'b0, 1'b0);
        repeat (20) sck_cycle(1'b0);
        end_frame("t7");

        // reset mid-DATA with cs held low
        ch0_data = 10'h2A5;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        send_cmd(0, 1'b1, 1'b0, 1'b1);
        repeat (6) sck_cycle(1'b0);
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(1);
        check("t8_rst_oe", {31'b0, sdo_oe}, 0);
        check("t8_rst_sdo", {31'b0, sdata_from_adc}, 0);
        check("t8_rst_chan_sel", {30'b0, chan_sel}, 0);
        check("t8_rst_state", {29'b0, state_dbg}, 0);
        reset = 1'b0;
        repeat (6) sck_cycle(1'b1);
        check("t8_idle_oe", {31'b0, sdo_oe}, 0);
        check("t8_idle_state", {29'b0, state_dbg}, 0);
        end_frame("t8");

        // a fresh frame works after the reset
        ch0_data = 10'h155;
        exp_q.push_back(1'b0); push_word(10'b0101010101); exp_q.push_back(1'b0);
        ev_q.push_back(2'b01);
        send_cmd(0, 1'b1, 1'b0, 1'b1);
        repeat (12) sck_cycle(1'b0);
        end_frame("t9");
        check("t9_chan_sel", {30'b0, chan_sel}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
